// File: rtl/pkt_fifo_pkg.sv
// Shared definitions for the packet FIFO: write-side FSM state encoding.
package pkt_fifo_pkg;

  // IDLE: no open packet; WRITE: open packet with uncommitted words;
  // DISCARD: swallowing the remainder of a dropped packet.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    DISCARD = 2'd2
  } wr_state_t;

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port storage for the packet FIFO: synchronous write,
// asynchronous (combinational) read. Contents are never reset.
module pkt_fifo_ram
  import pkt_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned WIDTH      = 33
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port: one word per clock when enabled
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Packet FIFO with commit-on-last semantics: words of a packet are written
// speculatively and only become visible to the reader once the last word
// has been enqueued.
// Optional feature macro: PKT_FIFO_DROP_EN enables din_drop handling and
// oversize-packet discard (with oversize_drop pulse). Without it din_drop is
// ignored and an oversize packet stalls the writer (a user error).
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 5,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ALMOST_FULL_DIST  = 2,
  parameter int unsigned ALMOST_EMPTY_DIST = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_last,
  input  logic                  din_drop,
  output logic                  din_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_last,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   item_count,
  output logic [ADDR_WIDTH:0]   pkt_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  oversize_drop
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t ONE     = ptr_t'(1);

  wr_state_t state, state_nxt;

  ptr_t wr_ptr, commit_ptr, rd_ptr;
  ptr_t wr_fill, free_words;

  logic enq, deq, accept_word, commit, drop_req, oversize_req;
  logic [DATA_WIDTH:0] rd_word;

  // Occupancy and status flags, all derived from the pointers
  assign wr_fill      = wr_ptr - rd_ptr;
  assign free_words   = DEPTH_P - wr_fill;
  assign full         = (wr_fill == DEPTH_P);
  assign item_count   = commit_ptr - rd_ptr;
  assign dout_valid   = (rd_ptr != commit_ptr);
  assign empty        = ~dout_valid;
  assign almost_full  = (32'(free_words) <= ALMOST_FULL_DIST);
  assign almost_empty = (32'(item_count) <= ALMOST_EMPTY_DIST);
  assign deq          = dout_valid & dout_ready;
  assign {dout_last, dout} = rd_word;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM outputs: handshake, write qualification, drop/oversize requests
  always_comb begin
    din_ready    = ~rst & ((state == DISCARD) | ~full);
    drop_req     = 1'b0;
    oversize_req = 1'b0;
`ifdef PKT_FIFO_DROP_EN
    drop_req     = (state == WRITE) & din_valid & din_drop;
    // A packet that fills the whole FIFO with nothing committed can never
    // complete, so it is abandoned rather than stalling forever.
    oversize_req = (state == WRITE) & full & (commit_ptr == rd_ptr) & ~drop_req;
`endif
    enq         = din_valid & din_ready;
    accept_word = enq & (state != DISCARD) & ~drop_req;
    commit      = accept_word & din_last;
  end

`ifndef PKT_FIFO_DROP_EN
  logic unused_drop;
  assign unused_drop = din_drop;
`endif

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept_word & ~din_last) state_nxt = WRITE;
      end
      WRITE: begin
        if (drop_req)          state_nxt = din_last ? IDLE : DISCARD;
        else if (oversize_req) state_nxt = DISCARD;
        else if (commit)       state_nxt = IDLE;
      end
      DISCARD: begin
        if (enq & din_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer and packet-count bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
    end else begin
      if (drop_req | oversize_req) wr_ptr <= commit_ptr;
      else if (accept_word)        wr_ptr <= wr_ptr + ONE;
      if (commit) commit_ptr <= wr_ptr + ONE;
      if (deq)    rd_ptr     <= rd_ptr + ONE;
      if (commit & ~(deq & dout_last))      pkt_count <= pkt_count + ONE;
      else if (~commit & deq & dout_last)   pkt_count <= pkt_count - ONE;
    end
  end

`ifdef PKT_FIFO_DROP_EN
  // One-cycle flag following the cycle an oversize packet was abandoned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oversize_drop <= 1'b0;
    else     oversize_drop <= oversize_req;
  end
`else
  assign oversize_drop = 1'b0;
`endif

  pkt_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (DATA_WIDTH + 1)
  ) u_ram (
    .clk   (clk),
    .we    (accept_word),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata ({din_last, din}),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_pkt_fifo.sv
// Self-checking bench for pkt_fifo (ADDR_WIDTH=2). Drop/oversize scenarios
// run only when PKT_FIFO_DROP_EN is defined.
`timescale 1ns/1ps
module tb_pkt_fifo;

  localparam int AW    = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_last = 1'b0;
  logic          din_drop = 1'b0;
  logic          din_ready;
  logic          dout_valid;
  logic [DW-1:0] dout;
  logic          dout_last;
  logic          dout_ready = 1'b0;
  logic [AW:0]   item_count, pkt_count;
  logic          full, empty, almost_full, almost_empty, oversize_drop;

  pkt_fifo #(
    .ADDR_WIDTH        (AW),
    .DATA_WIDTH        (DW),
    .ALMOST_FULL_DIST  (2),
    .ALMOST_EMPTY_DIST (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .din_valid     (din_valid),
    .din           (din),
    .din_last      (din_last),
    .din_drop      (din_drop),
    .din_ready     (din_ready),
    .dout_valid    (dout_valid),
    .dout          (dout),
    .dout_last     (dout_last),
    .dout_ready    (dout_ready),
    .item_count    (item_count),
    .pkt_count     (pkt_count),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .oversize_drop (oversize_drop)
  );

  always #5 clk = ~clk;

  // Scoreboard: committed words visible to the reader, and the open packet
  logic [DW:0] sb[$];
  logic [DW:0] pend[$];
  int sb_pkts    = 0;
  bit m_disc     = 1'b0;
  bit m_ovs      = 1'b0;
  bit acc        = 1'b0;
  int ovs_seen   = 0;
  int words_read = 0;
  int n_checks   = 0;
  int n_pass     = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_clear();
    sb.delete();
    pend.delete();
    sb_pkts = 0;
    m_disc  = 1'b0;
    m_ovs   = 1'b0;
  endtask

  // Compare all outputs against the model, then apply this edge's transfers
  task automatic eval();
    int sb0       = sb.size();
    int total     = sb.size() + pend.size();
    bit exp_full  = (total == DEPTH);
    bit exp_valid = (sb0 != 0);
    bit exp_ready = !rst && (m_disc || !exp_full);
    bit ovs_next  = 1'b0;
    bit drop_taken = 1'b0;

    check("dout_valid", dout_valid, exp_valid);
    check("empty", empty, !exp_valid);
    check("full", full, exp_full);
    check("din_ready", din_ready, exp_ready);
    check("item_count", item_count, sb0);
    check("pkt_count", pkt_count, sb_pkts);
    check("almost_full", almost_full, (DEPTH - total) <= 2);
    check("almost_empty", almost_empty, sb0 <= 2);
    check("oversize_drop", oversize_drop, m_ovs);
    if (exp_valid) check("dout_word", {dout_last, dout}, sb[0]);
    if (oversize_drop === 1'b1) ovs_seen++;

    acc = 1'b0;
    if (!rst) begin
      if (dout_ready && exp_valid) begin
        if (sb[0][DW]) sb_pkts--;
        void'(sb.pop_front());
        words_read++;
      end
`ifdef PKT_FIFO_DROP_EN
      if (pend.size() != 0 && din_valid && din_drop) begin
        pend.delete();
        m_disc     = !din_last;
        drop_taken = 1'b1;
        acc        = 1'b1;
      end else if (pend.size() != 0 && exp_full && sb0 == 0) begin
        pend.delete();
        m_disc   = 1'b1;
        ovs_next = 1'b1;
      end
`endif
      if (!drop_taken && !ovs_next && din_valid && exp_ready) begin
        acc = 1'b1;
        if (m_disc) begin
          if (din_last) m_disc = 1'b0;
        end else begin
          pend.push_back({din_last, din});
          if (din_last) begin
            foreach (pend[i]) sb.push_back(pend[i]);
            sb_pkts++;
            pend.delete();
          end
        end
      end
    end
    m_ovs = ovs_next;
  endtask

  task automatic tick();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit last, input bit drop);
    bit done = 1'b0;
    din_valid = 1'b1;
    din       = d;
    din_last  = last;
    din_drop  = drop;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = acc;
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
    din_drop  = 1'b0;
    if (!done) check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pkt(input int n, input int base);
    for (int i = 0; i < n; i++) send_word(DW'(base + i), (i == n - 1), 1'b0);
  endtask

  task automatic drain();
    bit done = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      done = (sb.size() == 0);
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_almost_empty"}, almost_empty, 1);
    check({tag, "_almost_full"}, almost_full, 0);
    check({tag, "_din_ready"}, din_ready, 0);
    check({tag, "_item_count"}, item_count, 0);
    check({tag, "_pkt_count"}, pkt_count, 0);
    check({tag, "_oversize"}, oversize_drop, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #1 rst = 1'b1;
    #1;
    check_reset_values("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Three-word packet stays invisible until after its last word
    dout_ready = 1'b0;
    send_word(16'h00A1, 1'b0, 1'b0);
    send_word(16'h00B2, 1'b0, 1'b0);
    check("pkt3_hidden", dout_valid, 0);
    send_word(16'h00C3, 1'b1, 1'b0);
    check("pkt3_visible", dout_valid, 1);
    check("pkt3_items", item_count, 3);
    check("pkt3_pkts", pkt_count, 1);
    drain();

    // Full FIFO: simultaneous read accepted, write refused
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(DW'(16'h1000 + k), 1'b1, 1'b0);
    check("full_flag", full, 1);
    check("full_ready", din_ready, 0);
    check("full_items", item_count, 4);
    check("full_pkts", pkt_count, 4);
    din_valid  = 1'b1;
    din        = 16'h1FFF;
    din_last   = 1'b1;
    dout_ready = 1'b1;
    tick();
    din_valid  = 1'b0;
    din_last   = 1'b0;
    dout_ready = 1'b0;
    check("full_rw_items", item_count, 3);
    check("full_rw_full", full, 0);
    drain();

`ifdef PKT_FIFO_DROP_EN
    // Drop of an open packet leaves committed data untouched
    dout_ready = 1'b0;
    send_word(16'h2001, 1'b1, 1'b0);
    send_word(16'h2101, 1'b0, 1'b0);
    send_word(16'h2102, 1'b0, 1'b0);
    send_word(16'h21FF, 1'b1, 1'b1);
    check("drop_items", item_count, 1);
    check("drop_pkts", pkt_count, 1);
    check("drop_rewound", almost_full, 0);
    send_pkt(2, 16'h2200);
    drain();

    // Drop without last: rest of packet swallowed
    dout_ready = 1'b0;
    send_word(16'h3001, 1'b0, 1'b0);
    send_word(16'h30FF, 1'b0, 1'b1);
    send_word(16'h3002, 1'b1, 1'b0);
    tick();
    check("discard_empty", empty, 1);
    check("discard_items", item_count, 0);

    // Oversize packet into an empty FIFO
    ovs_seen   = 0;
    dout_ready = 1'b1;
    send_pkt(6, 16'h4000);
    tick();
    check("oversize_pulses", ovs_seen, 1);
    check("oversize_empty", empty, 1);
    check("oversize_items", item_count, 0);
`endif

    // Asynchronous reset in the middle of a packet
    dout_ready = 1'b0;
    send_word(16'h5001, 1'b1, 1'b0);
    send_word(16'h5101, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    model_clear();
    tick();
    rst = 1'b0;
    send_pkt(2, 16'h5200);
    check("midrst_items", item_count, 2);
    drain();

    // Continuous streaming across several pointer wraps
    words_read = 0;
    dout_ready = 1'b1;
    for (int p = 0; p < 6; p++) send_pkt(2, 16'h6000 + 2 * p);
    drain();
    check("stream_words", words_read, 12);
    check("stream_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
